axi_mem_responder: RTL and testbench

AXI4 subordinate (responder) that terminates the memory-side AXI bus driven by the core's memory controller, backing it with an internal word-addressed RAM. It accepts INCR bursts on independent read and write channels, one outstanding transaction per direction, and streams one beat per cycle. It is the simulation/FPGA main-memory model that sits directly on the SoC's `s_axi_*` master ports.

---
 rtl/axi_mem_responder_if.sv | 72 +++++++
 rtl/axi_mem_responder.sv | 201 ++++++++++++++++++++
 tb/tb_axi_mem_responder.sv | 258 +++++++++++++++++++++++++
 3 files changed

// File: rtl/axi_mem_responder_if.sv
// Memory-side AXI4 bus: master is the core's memory controller,
// slave is the memory responder.
`ifndef AXI_ID_LEN
`define AXI_ID_LEN 4
`endif
interface axi_mem_responder_if #(
   parameter int WIDTH    = 128,
   parameter int ADDR_LEN = 32,
   parameter int ID_LEN   = `AXI_ID_LEN
);
   logic [ID_LEN-1:0]   s_axi_awid;
   logic [ADDR_LEN-1:0] s_axi_awaddr;
   logic [7:0]          s_axi_awlen;
   logic [2:0]          s_axi_awsize;
   logic [1:0]          s_axi_awburst;
   logic                s_axi_awlock;
   logic [3:0]          s_axi_awcache;
   logic                s_axi_awvalid;
   logic                s_axi_awready;
   logic [WIDTH-1:0]    s_axi_wdata;
   logic [WIDTH/8-1:0]  s_axi_wstrb;
   logic                s_axi_wlast;
   logic                s_axi_wvalid;
   logic                s_axi_wready;
   logic [ID_LEN-1:0]   s_axi_bid;
   logic                s_axi_bvalid;
   logic                s_axi_bready;
   logic [ID_LEN-1:0]   s_axi_arid;
   logic [ADDR_LEN-1:0] s_axi_araddr;
   logic [7:0]          s_axi_arlen;
   logic [2:0]          s_axi_arsize;
   logic [1:0]          s_axi_arburst;
   logic                s_axi_arlock;
   logic [3:0]          s_axi_arcache;
   logic                s_axi_arvalid;
   logic                s_axi_arready;
   logic [ID_LEN-1:0]   s_axi_rid;
   logic [WIDTH-1:0]    s_axi_rdata;
   logic                s_axi_rlast;
   logic                s_axi_rvalid;
   logic                s_axi_rready;

   modport master (
      output s_axi_awid, s_axi_awaddr, s_axi_awlen, s_axi_awsize,
      output s_axi_awburst, s_axi_awlock, s_axi_awcache, s_axi_awvalid,
      input  s_axi_awready,
      output s_axi_wdata, s_axi_wstrb, s_axi_wlast, s_axi_wvalid,
      input  s_axi_wready,
      input  s_axi_bid, s_axi_bvalid,
      output s_axi_bready,
      output s_axi_arid, s_axi_araddr, s_axi_arlen, s_axi_arsize,
      output s_axi_arburst, s_axi_arlock, s_axi_arcache, s_axi_arvalid,
      input  s_axi_arready,
      input  s_axi_rid, s_axi_rdata, s_axi_rlast, s_axi_rvalid,
      output s_axi_rready
   );

   modport slave (
      input  s_axi_awid, s_axi_awaddr, s_axi_awlen, s_axi_awsize,
      input  s_axi_awburst, s_axi_awlock, s_axi_awcache, s_axi_awvalid,
      output s_axi_awready,
      input  s_axi_wdata, s_axi_wstrb, s_axi_wlast, s_axi_wvalid,
      output s_axi_wready,
      output s_axi_bid, s_axi_bvalid,
      input  s_axi_bready,
      input  s_axi_arid, s_axi_araddr, s_axi_arlen, s_axi_arsize,
      input  s_axi_arburst, s_axi_arlock, s_axi_arcache, s_axi_arvalid,
      output s_axi_arready,
      output s_axi_rid, s_axi_rdata, s_axi_rlast, s_axi_rvalid,
      input  s_axi_rready
   );
endinterface

// File: rtl/axi_mem_responder.sv
// AXI4 burst memory responder over a word RAM, one burst per direction.
// Define AXI_MEM_RANDOM_STALL_EN for LFSR-driven backpressure stress.
`ifndef AXI_ID_LEN
`define AXI_ID_LEN 4
`endif
module axi_mem_responder #(
   parameter int WIDTH    = 128,
   parameter int ADDR_LEN = 32,
   parameter int ID_LEN   = `AXI_ID_LEN,
   parameter int DEPTH_E  = 16
) (
   input  logic               clk,
   input  logic               rst,
   axi_mem_responder_if.slave bus,
   output logic               OUT_err
);
   localparam int NB  = WIDTH / 8;
   localparam int OFF = $clog2(NB);

   typedef logic [DEPTH_E-1:0] idx_t;
   typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} wstate_t;
   typedef enum logic {R_IDLE, R_BURST} rstate_t;

   logic [WIDTH-1:0] mem [2**DEPTH_E];

   wstate_t           wst_q, wst_d;
   rstate_t           rs_q, rs_d;
   logic              live_q;
   idx_t              w_idx_q, w_idx_d;
   logic [8:0]        w_cnt_q, w_cnt_d;
   logic [ID_LEN-1:0] w_id_q, w_id_d;
   logic              w_fix_q, w_fix_d;
   logic              err_q, err_d;
   idx_t              r_idx_q, r_idx_d;
   logic [7:0]        r_cnt_q, r_cnt_d;
   logic              r_fix_q, r_fix_d;
   logic [ID_LEN-1:0] rid_q, rid_d;
   logic              rvalid_q, rvalid_d;
   logic              rlast_q, rlast_d;
   logic [WIDTH-1:0]  rdata_q, rdata_d;

   logic stall, mem_we, r_ld;
   logic aw_hs, w_hs, ar_hs, r_hs;
   idx_t aw_idx, ar_idx, rd_idx;
   logic unused;

   assign unused = ^{bus.s_axi_awaddr, bus.s_axi_araddr,
                     bus.s_axi_awsize, bus.s_axi_awlock, bus.s_axi_awcache,
                     bus.s_axi_arsize, bus.s_axi_arlock, bus.s_axi_arcache};

`ifdef AXI_MEM_RANDOM_STALL_EN
   logic [15:0] lfsr_q, lfsr_d;
   always_comb begin
      lfsr_d = {lfsr_q[14:0],
                lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};
   end
   always_ff @(posedge clk) begin
      if (!rst) lfsr_q <= 16'hACE1;
      else      lfsr_q <= lfsr_d;
   end
   assign stall = lfsr_q[0];
`else
   assign stall = 1'b0;
`endif

   assign aw_idx = bus.s_axi_awaddr[OFF +: DEPTH_E];
   assign ar_idx = bus.s_axi_araddr[OFF +: DEPTH_E];

   // live_q holds ready low for the first cycle after reset release
   assign bus.s_axi_awready = live_q && !stall && (wst_q == W_IDLE);
   assign bus.s_axi_wready  = !stall && (wst_q == W_DATA);
   assign bus.s_axi_bvalid  = (wst_q == W_RESP);
   assign bus.s_axi_bid     = w_id_q;
   assign bus.s_axi_arready = live_q && !stall && (rs_q == R_IDLE);
   assign bus.s_axi_rvalid  = rvalid_q;
   assign bus.s_axi_rdata   = rdata_q;
   assign bus.s_axi_rid     = rid_q;
   assign bus.s_axi_rlast   = rlast_q;
   assign OUT_err           = err_q;

   assign aw_hs = bus.s_axi_awvalid && bus.s_axi_awready;
   assign w_hs  = bus.s_axi_wvalid && bus.s_axi_wready;
   assign ar_hs = bus.s_axi_arvalid && bus.s_axi_arready;
   assign r_hs  = rvalid_q && bus.s_axi_rready;

   always_comb begin
      wst_d   = wst_q;
      w_idx_d = w_idx_q;
      w_cnt_d = w_cnt_q;
      w_id_d  = w_id_q;
      w_fix_d = w_fix_q;
      err_d   = err_q;
      mem_we  = 1'b0;
      unique case (wst_q)
         W_IDLE: if (aw_hs) begin
            w_idx_d = aw_idx;
            w_cnt_d = {1'b0, bus.s_axi_awlen} + 9'd1;
            w_id_d  = bus.s_axi_awid;
            w_fix_d = (bus.s_axi_awburst == 2'b00);
            wst_d   = W_DATA;
         end
         W_DATA: if (w_hs) begin
            mem_we  = rst;
            w_cnt_d = w_cnt_q - 9'd1;
            if (!w_fix_q) w_idx_d = w_idx_q + idx_t'(1);
            if (bus.s_axi_wlast != (w_cnt_q == 9'd1)) err_d = 1'b1;
            if (w_cnt_q == 9'd1) wst_d = W_RESP;
         end
         W_RESP: if (bus.s_axi_bready) wst_d = W_IDLE;
         default: wst_d = W_IDLE;
      endcase
   end

   always_comb begin
      rs_d     = rs_q;
      r_idx_d  = r_idx_q;
      r_cnt_d  = r_cnt_q;
      r_fix_d  = r_fix_q;
      rid_d    = rid_q;
      rvalid_d = rvalid_q;
      rlast_d  = rlast_q;
      rdata_d  = rdata_q;
      rd_idx   = r_idx_q;
      r_ld     = 1'b0;
      if (r_hs) rvalid_d = 1'b0;
      unique case (rs_q)
         // first beat is fetched straight off the AR address
         R_IDLE: if (ar_hs) begin
            r_ld    = 1'b1;
            rd_idx  = ar_idx;
            rid_d   = bus.s_axi_arid;
            rlast_d = (bus.s_axi_arlen == 8'd0);
            r_cnt_d = bus.s_axi_arlen;
            r_fix_d = (bus.s_axi_arburst == 2'b00);
            r_idx_d = r_fix_d ? ar_idx : ar_idx + idx_t'(1);
            rs_d    = R_BURST;
         end
         R_BURST: begin
            if (r_cnt_q != 8'd0 && !stall &&
                (!rvalid_q || bus.s_axi_rready)) begin
               r_ld    = 1'b1;
               rlast_d = (r_cnt_q == 8'd1);
               r_cnt_d = r_cnt_q - 8'd1;
               if (!r_fix_q) r_idx_d = r_idx_q + idx_t'(1);
            end else if (r_hs && rlast_q) begin
               rs_d = R_IDLE;
            end
         end
      endcase
      if (r_ld) begin
         rvalid_d = 1'b1;
         rdata_d  = mem[rd_idx];
      end
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         wst_q    <= W_IDLE;
         rs_q     <= R_IDLE;
         live_q   <= 1'b0;
         w_idx_q  <= '0;
         w_cnt_q  <= '0;
         w_id_q   <= '0;
         w_fix_q  <= 1'b0;
         err_q    <= 1'b0;
         r_idx_q  <= '0;
         r_cnt_q  <= '0;
         r_fix_q  <= 1'b0;
         rid_q    <= '0;
         rvalid_q <= 1'b0;
         rlast_q  <= 1'b0;
         rdata_q  <= '0;
      end else begin
         wst_q    <= wst_d;
         rs_q     <= rs_d;
         live_q   <= 1'b1;
         w_idx_q  <= w_idx_d;
         w_cnt_q  <= w_cnt_d;
         w_id_q   <= w_id_d;
         w_fix_q  <= w_fix_d;
         err_q    <= err_d;
         r_idx_q  <= r_idx_d;
         r_cnt_q  <= r_cnt_d;
         r_fix_q  <= r_fix_d;
         rid_q    <= rid_d;
         rvalid_q <= rvalid_d;
         rlast_q  <= rlast_d;
         rdata_q  <= rdata_d;
      end
   end

   // RAM keeps its contents across reset
   always_ff @(posedge clk) begin
      if (mem_we) begin
         for (int b = 0; b < NB; b++) begin
            if (bus.s_axi_wstrb[b])
               mem[w_idx_q][b*8 +: 8] <= bus.s_axi_wdata[b*8 +: 8];
         end
      end
   end
endmodule

// File: tb/tb_axi_mem_responder.sv
// Directed bench for axi_mem_responder: vector table plus
// hand sequences for stalls, wlast errors and mid-burst reset.
module tb_axi_mem_responder;
   logic clk = 1'b0;
   logic rst = 1'b0;
   logic err;
   int   checks = 0;
   int   errors = 0;
   logic [127:0] rd_buf [256];

   always #5 clk = ~clk;

   axi_mem_responder_if #(.WIDTH(128), .ADDR_LEN(32), .ID_LEN(4)) bus ();

   axi_mem_responder #(
      .WIDTH(128), .ADDR_LEN(32), .ID_LEN(4), .DEPTH_E(16)
   ) dut (
      .clk(clk),
      .rst(rst),
      .bus(bus.slave),
      .OUT_err(err)
   );

   typedef struct {
      bit           wr;
      logic [31:0]  addr;
      logic [7:0]   len;
      logic [1:0]   burst;
      logic [3:0]   id;
      logic [127:0] base;
      logic [127:0] step;
      logic [15:0]  strb;
   } vec_t;

   vec_t tv [15];

   task automatic chk(input string name, input logic [127:0] act,
                      input logic [127:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s got=%h want=%h", name, act, exp);
      end
   endtask

   task automatic timeout(input string name);
      checks++;
      errors++;
      $display("FAIL %s timeout", name);
   endtask

   task automatic write_burst(input logic [31:0] addr, input logic [7:0] len,
                              input logic [1:0] burst, input logic [3:0] id,
                              input logic [127:0] base, input logic [127:0] step,
                              input logic [15:0] strb, input int early);
      int cyc;
      bus.s_axi_awid    = id;
      bus.s_axi_awaddr  = addr;
      bus.s_axi_awlen   = len;
      bus.s_axi_awburst = burst;
      bus.s_axi_awvalid = 1'b1;
      cyc = 0;
      while (!bus.s_axi_awready && cyc < 100) begin
         @(posedge clk); #1; cyc++;
      end
      if (!bus.s_axi_awready) begin
         timeout("awready");
         bus.s_axi_awvalid = 1'b0;
         return;
      end
      @(posedge clk); #1;
      bus.s_axi_awvalid = 1'b0;
      for (int k = 0; k <= int'(len); k++) begin
         bus.s_axi_wdata  = base + step * 128'(k);
         bus.s_axi_wstrb  = strb;
         bus.s_axi_wlast  = (k == int'(len)) || (k == early);
         bus.s_axi_wvalid = 1'b1;
         if (k == 0) chk("w_lat", bus.s_axi_wready, 1'b1);
         cyc = 0;
         while (!bus.s_axi_wready && cyc < 100) begin
            @(posedge clk); #1; cyc++;
         end
         if (!bus.s_axi_wready) timeout("wready");
         if (k == int'(len)) chk("b_early", bus.s_axi_bvalid, 1'b0);
         @(posedge clk); #1;
      end
      bus.s_axi_wvalid = 1'b0;
      bus.s_axi_wlast  = 1'b0;
      chk("b_lat", bus.s_axi_bvalid, 1'b1);
      chk("bid", bus.s_axi_bid, id);
      bus.s_axi_bready = 1'b1;
      @(posedge clk); #1;
      bus.s_axi_bready = 1'b0;
      chk("aw_again", bus.s_axi_awready, 1'b1);
   endtask

   task automatic read_burst(input logic [31:0] addr, input logic [7:0] len,
                             input logic [1:0] burst, input logic [3:0] id,
                             input bit tog);
      int cyc, k, lastbad, stallbad;
      bit was_stall;
      logic [127:0] held;
      bus.s_axi_arid    = id;
      bus.s_axi_araddr  = addr;
      bus.s_axi_arlen   = len;
      bus.s_axi_arburst = burst;
      bus.s_axi_arvalid = 1'b1;
      cyc = 0;
      while (!bus.s_axi_arready && cyc < 100) begin
         @(posedge clk); #1; cyc++;
      end
      if (!bus.s_axi_arready) begin
         timeout("arready");
         bus.s_axi_arvalid = 1'b0;
         return;
      end
      @(posedge clk); #1;
      bus.s_axi_arvalid = 1'b0;
      chk("r_lat", bus.s_axi_rvalid, 1'b1);
      chk("rid", bus.s_axi_rid, id);
      k = 0; cyc = 0; lastbad = 0; stallbad = 0;
      was_stall = 1'b0; held = '0;
      while (k <= int'(len) && cyc < 2000) begin
         bus.s_axi_rready = tog ? (cyc % 2 == 0) : 1'b1;
         if (bus.s_axi_rvalid && bus.s_axi_rready) begin
            rd_buf[k] = bus.s_axi_rdata;
            if (bus.s_axi_rlast !== (k == int'(len))) lastbad++;
            k++;
            was_stall = 1'b0;
         end else if (bus.s_axi_rvalid) begin
            held = bus.s_axi_rdata;
            was_stall = 1'b1;
         end
         @(posedge clk); #1; cyc++;
         if (was_stall && (bus.s_axi_rdata !== held || !bus.s_axi_rvalid))
            stallbad++;
      end
      bus.s_axi_rready = 1'b0;
      if (k <= int'(len)) timeout("rbeats");
      chk("rlast_pos", lastbad, 0);
      if (tog) chk("r_stable", stallbad, 0);
      chk("ar_again", bus.s_axi_arready, 1'b1);
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog");
      $fatal(1, "watchdog");
   end

   initial begin
      int n, cyc;
      logic [127:0] r1, a, c, b, f5;
      r1 = {32{4'h1}};
      a  = {32{4'hA}};
      c  = {32{4'hC}};
      b  = {32{4'hB}};
      f5 = {32{4'h5}};
      tv[0]  = '{1'b1, 32'h0000_0100, 8'd3, 2'b01, 4'd1, r1, r1, 16'hFFFF};
      tv[1]  = '{1'b0, 32'h0000_0100, 8'd3, 2'b01, 4'd1, r1, r1, 16'h0};
      tv[2]  = '{1'b1, 32'h0000_0200, 8'd0, 2'b01, 4'd2, '1, '0, 16'hFFFF};
      tv[3]  = '{1'b1, 32'h0000_0200, 8'd0, 2'b01, 4'd3, '0, '0, 16'h000F};
      tv[4]  = '{1'b0, 32'h0000_0200, 8'd0, 2'b01, 4'd4,
                 {{96{1'b1}}, 32'h0}, '0, 16'h0};
      tv[5]  = '{1'b1, 32'h0000_0300, 8'd2, 2'b00, 4'd5, a, 128'd1, 16'hFFFF};
      tv[6]  = '{1'b0, 32'h0000_0300, 8'd2, 2'b00, 4'd5,
                 {{31{4'hA}}, 4'hC}, '0, 16'h0};
      tv[7]  = '{1'b1, 32'h000F_FFE0, 8'd3, 2'b01, 4'd6, c, 128'd1, 16'hFFFF};
      tv[8]  = '{1'b0, 32'h000F_FFE0, 8'd1, 2'b01, 4'd6, c, 128'd1, 16'h0};
      tv[9]  = '{1'b0, 32'h001F_FFF0, 8'd0, 2'b01, 4'd7,
                 {{31{4'hC}}, 4'hD}, '0, 16'h0};
      tv[10] = '{1'b0, 32'h0010_0000, 8'd1, 2'b01, 4'd8,
                 {{31{4'hC}}, 4'hE}, 128'd1, 16'h0};
      tv[11] = '{1'b1, 32'h0000_0400, 8'd1, 2'b10, 4'd9, f5, 128'd1, 16'hFFFF};
      tv[12] = '{1'b0, 32'h0000_0400, 8'd1, 2'b11, 4'd9, f5, 128'd1, 16'h0};
      tv[13] = '{1'b0, 32'h0000_010C, 8'd0, 2'b01, 4'd10, r1, '0, 16'h0};
      tv[14] = '{1'b1, 32'h0000_0800, 8'd7, 2'b01, 4'd11, b, 128'd1, 16'hFFFF};

      bus.s_axi_awid = '0;   bus.s_axi_awaddr = '0;  bus.s_axi_awlen = '0;
      bus.s_axi_awsize = 3'd4; bus.s_axi_awburst = 2'b01;
      bus.s_axi_awlock = 1'b0; bus.s_axi_awcache = '0;
      bus.s_axi_awvalid = 1'b0;
      bus.s_axi_wdata = '0;  bus.s_axi_wstrb = '0;  bus.s_axi_wlast = 1'b0;
      bus.s_axi_wvalid = 1'b0; bus.s_axi_bready = 1'b0;
      bus.s_axi_arid = '0;   bus.s_axi_araddr = '0;  bus.s_axi_arlen = '0;
      bus.s_axi_arsize = 3'd4; bus.s_axi_arburst = 2'b01;
      bus.s_axi_arlock = 1'b0; bus.s_axi_arcache = '0;
      bus.s_axi_arvalid = 1'b0; bus.s_axi_rready = 1'b0;

      rst = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      chk("rst_ready", {bus.s_axi_awready, bus.s_axi_wready,
                        bus.s_axi_arready}, 3'b000);
      chk("rst_valid", {bus.s_axi_bvalid, bus.s_axi_rvalid,
                        bus.s_axi_rlast, err}, 4'b0000);
      chk("rst_ids", {bus.s_axi_bid, bus.s_axi_rid}, 8'h00);
      chk("rst_rdata", bus.s_axi_rdata, '0);
      rst = 1'b1;
      @(posedge clk); #1;
      chk("rel_ready", {bus.s_axi_awready, bus.s_axi_arready}, 2'b11);

      for (int i = 0; i < 15; i++) begin
         if (tv[i].wr) begin
            write_burst(tv[i].addr, tv[i].len, tv[i].burst, tv[i].id,
                        tv[i].base, tv[i].step, tv[i].strb, -1);
         end else begin
            read_burst(tv[i].addr, tv[i].len, tv[i].burst, tv[i].id, 1'b0);
            for (int k = 0; k <= int'(tv[i].len); k++)
               chk($sformatf("v%0d_b%0d", i, k), rd_buf[k],
                   tv[i].base + tv[i].step * 128'(k));
         end
      end

      read_burst(32'h0000_0800, 8'd7, 2'b01, 4'd12, 1'b1);
      for (int k = 0; k < 8; k++)
         chk($sformatf("tog_b%0d", k), rd_buf[k], b + 128'(k));

      chk("err_clean", err, 1'b0);
      write_burst(32'h0000_0900, 8'd3, 2'b01, 4'd13, f5, f5, 16'hFFFF, 1);
      chk("err_set", err, 1'b1);
      read_burst(32'h0000_0900, 8'd3, 2'b01, 4'd13, 1'b0);
      for (int k = 0; k < 4; k++)
         chk($sformatf("wl_b%0d", k), rd_buf[k], f5 * 128'(k + 1));
      chk("err_sticky", err, 1'b1);

      bus.s_axi_arid    = 4'd14;
      bus.s_axi_araddr  = 32'h0000_0800;
      bus.s_axi_arlen   = 8'd7;
      bus.s_axi_arburst = 2'b01;
      bus.s_axi_arvalid = 1'b1;
      @(posedge clk); #1;
      bus.s_axi_arvalid = 1'b0;
      bus.s_axi_rready  = 1'b1;
      n = 0; cyc = 0;
      while (n < 3 && cyc < 50) begin
         if (bus.s_axi_rvalid) n++;
         @(posedge clk); #1; cyc++;
      end
      if (n < 3) timeout("mid_beats");
      chk("mid_beat3", bus.s_axi_rdata, b + 128'd3);
      rst = 1'b0;
      bus.s_axi_rready = 1'b0;
      @(posedge clk); #1;
      chk("mid_rst_rvalid", bus.s_axi_rvalid, 1'b0);
      chk("mid_rst_arready", bus.s_axi_arready, 1'b0);
      chk("mid_rst_err", err, 1'b0);
      rst = 1'b1;
      @(posedge clk); #1;
      chk("mid_rel_arready", bus.s_axi_arready, 1'b1);
      read_burst(32'h0000_0100, 8'd3, 2'b01, 4'd15, 1'b0);
      for (int k = 0; k < 4; k++)
         chk($sformatf("keep_b%0d", k), rd_buf[k], r1 * 128'(k + 1));

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
